// File: rtl/duck_pkg.sv
// rtl/duck_pkg.sv - shared state type, widths and default frame counts for the duck round controller
package duck_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_FLY,
    ST_FALL,
    ST_ESCAPE,
    ST_ROUND_END,
    ST_GAME_OVER
  } round_state_t;

  localparam int TW = 10;
  localparam int SW = 16;

  localparam int FLY_FRAMES  = 300;
  localparam int FALL_FRAMES = 60;
  localparam int ESC_FRAMES  = 90;
  localparam int END_FRAMES  = 120;

  localparam int SHOTS    = 3;
  localparam int DUCKS    = 10;
  localparam int MIN_HITS = 6;
  localparam int POINTS   = 100;

endpackage

// File: rtl/duck_round_fsm.sv
// rtl/duck_round_fsm.sv - one-round game flow: spawn, fly, fall/escape, round end; drives down_counter
module duck_round_fsm #(
  parameter int TW          = duck_pkg::TW,
  parameter int FLY_FRAMES  = duck_pkg::FLY_FRAMES,
  parameter int FALL_FRAMES = duck_pkg::FALL_FRAMES,
  parameter int ESC_FRAMES  = duck_pkg::ESC_FRAMES,
  parameter int END_FRAMES  = duck_pkg::END_FRAMES,
  parameter int SHOTS       = duck_pkg::SHOTS,
  parameter int DUCKS       = duck_pkg::DUCKS,
  parameter int MIN_HITS    = duck_pkg::MIN_HITS,
  parameter int POINTS      = duck_pkg::POINTS,
  parameter int SW          = duck_pkg::SW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          frame_tick,
  input  logic          shot,
  input  logic          hit,
  input  logic          timer_done,
  output logic          timer_ld,
  output logic [TW-1:0] timer_data,
  output logic          timer_en,
  output logic          duck_active,
  output logic          duck_falling,
  output logic          duck_escaping,
  output logic [1:0]    shots_left,
  output logic [3:0]    hit_count,
  output logic [3:0]    duck_idx,
  output logic [7:0]    round_num,
  output logic [SW-1:0] score,
  output logic          game_over
);
  import duck_pkg::*;

  localparam logic [TW-1:0] FLY_LOAD  = TW'(FLY_FRAMES - 1);
  localparam logic [TW-1:0] FALL_LOAD = TW'(FALL_FRAMES - 1);
  localparam logic [TW-1:0] ESC_LOAD  = TW'(ESC_FRAMES - 1);
  localparam logic [TW-1:0] END_LOAD  = TW'(END_FRAMES - 1);
  localparam logic [3:0]    LAST_DUCK = 4'(DUCKS - 1);

  round_state_t  state_q, state_d;
  logic          timer_ld_q, timer_ld_d;
  logic [TW-1:0] timer_data_q, timer_data_d;
  logic          duck_active_q, duck_active_d;
  logic          duck_falling_q, duck_falling_d;
  logic          duck_escaping_q, duck_escaping_d;
  logic [1:0]    shots_left_q, shots_left_d;
  logic [3:0]    hit_count_q, hit_count_d;
  logic [3:0]    duck_idx_q, duck_idx_d;
  logic [7:0]    round_num_q, round_num_d;
  logic [SW-1:0] score_q, score_d;
  logic          game_over_q, game_over_d;

  logic          done_ok;
  logic [SW:0]   score_sum;
  logic [SW-1:0] score_sat;

  // A done seen during the load cycle is the previous interval's sticky flag.
  assign done_ok   = timer_done & ~timer_ld_q;
  assign score_sum = {1'b0, score_q} + (SW+1)'(POINTS);
  assign score_sat = score_sum[SW] ? {SW{1'b1}} : score_sum[SW-1:0];

  always_comb begin
    state_d      = state_q;
    timer_ld_d   = 1'b0;
    timer_data_d = timer_data_q;
    shots_left_d = shots_left_q;
    hit_count_d  = hit_count_q;
    duck_idx_d   = duck_idx_q;
    round_num_d  = round_num_q;
    score_d      = score_q;

    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start) begin
          score_d     = '0;
          hit_count_d = '0;
          duck_idx_d  = '0;
          round_num_d = 8'd1;
          state_d     = ST_SPAWN;
        end
      end
      ST_SPAWN: begin
        shots_left_d = 2'(SHOTS);
        state_d      = ST_FLY;
        timer_ld_d   = 1'b1;
        timer_data_d = FLY_LOAD;
      end
      ST_FLY: begin
        if (shot && shots_left_q != 2'd0) begin
          shots_left_d = shots_left_q - 2'd1;
          if (hit) begin
            score_d      = score_sat;
            hit_count_d  = hit_count_q + 4'd1;
            state_d      = ST_FALL;
            timer_ld_d   = 1'b1;
            timer_data_d = FALL_LOAD;
          end else if (shots_left_q == 2'd1 || done_ok) begin
            state_d      = ST_ESCAPE;
            timer_ld_d   = 1'b1;
            timer_data_d = ESC_LOAD;
          end
        end else if (done_ok) begin
          state_d      = ST_ESCAPE;
          timer_ld_d   = 1'b1;
          timer_data_d = ESC_LOAD;
        end
      end
      ST_FALL, ST_ESCAPE: begin
        if (done_ok) begin
          if (duck_idx_q == LAST_DUCK) begin
            state_d      = ST_ROUND_END;
            timer_ld_d   = 1'b1;
            timer_data_d = END_LOAD;
          end else begin
            duck_idx_d = duck_idx_q + 4'd1;
            state_d    = ST_SPAWN;
          end
        end
      end
      ST_ROUND_END: begin
        if (done_ok) begin
          if (hit_count_q >= 4'(MIN_HITS)) begin
            round_num_d = (round_num_q == 8'hFF) ? round_num_q : round_num_q + 8'd1;
            hit_count_d = '0;
            duck_idx_d  = '0;
            state_d     = ST_SPAWN;
          end else begin
            state_d = ST_GAME_OVER;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    duck_active_d   = (state_d == ST_FLY);
    duck_falling_d  = (state_d == ST_FALL);
    duck_escaping_d = (state_d == ST_ESCAPE);
    game_over_d     = (state_d == ST_GAME_OVER);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      timer_ld_q      <= 1'b0;
      timer_data_q    <= '0;
      duck_active_q   <= 1'b0;
      duck_falling_q  <= 1'b0;
      duck_escaping_q <= 1'b0;
      shots_left_q    <= '0;
      hit_count_q     <= '0;
      duck_idx_q      <= '0;
      round_num_q     <= '0;
      score_q         <= '0;
      game_over_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_ld_q      <= timer_ld_d;
      timer_data_q    <= timer_data_d;
      duck_active_q   <= duck_active_d;
      duck_falling_q  <= duck_falling_d;
      duck_escaping_q <= duck_escaping_d;
      shots_left_q    <= shots_left_d;
      hit_count_q     <= hit_count_d;
      duck_idx_q      <= duck_idx_d;
      round_num_q     <= round_num_d;
      score_q         <= score_d;
      game_over_q     <= game_over_d;
    end
  end

  assign timer_en      = frame_tick & ~timer_ld_q;
  assign timer_ld      = timer_ld_q;
  assign timer_data    = timer_data_q;
  assign duck_active   = duck_active_q;
  assign duck_falling  = duck_falling_q;
  assign duck_escaping = duck_escaping_q;
  assign shots_left    = shots_left_q;
  assign hit_count     = hit_count_q;
  assign duck_idx      = duck_idx_q;
  assign round_num     = round_num_q;
  assign score         = score_q;
  assign game_over     = game_over_q;

endmodule

// File: tb/tb_duck_round_fsm.sv
// tb/tb_duck_round_fsm.sv - directed vector bench for duck_round_fsm with a down_counter model
module tb_duck_round_fsm;

  logic        clk = 1'b0;
  logic        reset, start, frame_tick, shot, hit, timer_done;
  logic        timer_ld, timer_en;
  logic [9:0]  timer_data;
  logic        duck_active, duck_falling, duck_escaping, game_over;
  logic [1:0]  shots_left;
  logic [3:0]  hit_count, duck_idx;
  logic [7:0]  round_num;
  logic [15:0] score;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  duck_round_fsm dut (
    .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
    .shot(shot), .hit(hit), .timer_done(timer_done),
    .timer_ld(timer_ld), .timer_data(timer_data), .timer_en(timer_en),
    .duck_active(duck_active), .duck_falling(duck_falling), .duck_escaping(duck_escaping),
    .shots_left(shots_left), .hit_count(hit_count), .duck_idx(duck_idx),
    .round_num(round_num), .score(score), .game_over(game_over)
  );

  // down_counter model: done on the (data+1)th enabled tick after a load, sticky until reload
  logic [9:0] mcnt;
  logic       mdone;
  logic       stale_req;

  always_ff @(posedge clk) begin
    if (timer_ld) begin
      mcnt  <= timer_data;
      mdone <= 1'b0;
    end else if (stale_req) begin
      mdone <= 1'b1;
    end else if (timer_en) begin
      if (mcnt == 10'd0) mdone <= 1'b1;
      else               mcnt  <= mcnt - 10'd1;
    end
  end

  assign timer_done = mdone;

  typedef struct {
    bit st; bit sh; bit ht;
    int e_shots; int e_act; int e_fall; int e_esc; int e_ld;
    int e_data; int e_score; int e_hits; int e_duck;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input bit st, input bit sh, input bit ht, input bit tk);
    start = st; shot = sh; hit = ht; frame_tick = tk;
    @(posedge clk);
    #1;
  endtask

  task automatic to_next_fly(input string nm);
    int n = 0;
    while (!duck_active && n < 400) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      n++;
    end
    chk({nm, "_reach_fly"}, duck_active, 1);
  endtask

  task automatic run_duck(input bit do_hit, input string nm);
    int n = 0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    if (do_hit) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      chk({nm, "_fall"}, duck_falling, 1);
    end else begin
      repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk({nm, "_escape"}, duck_escaping, 1);
    end
    while ((duck_falling || duck_escaping) && n < 200) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      n++;
    end
    chk({nm, "_anim_end"}, duck_falling | duck_escaping, 0);
  endtask

  task automatic play_round(input bit [9:0] pat, input string nm);
    for (int d = 0; d < 10; d++) begin
      chk({nm, "_duck_idx"}, duck_idx, d);
      run_duck(pat[d], nm);
      if (d < 9) to_next_fly(nm);
    end
  endtask

  task automatic wait_game_over(input string nm);
    int n = 0;
    while (!game_over && n < 300) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      n++;
    end
    chk({nm, "_game_over"}, game_over, 1);
  endtask

  function automatic longint all_outs();
    return longint'({timer_ld, timer_data, timer_en, duck_active, duck_falling, duck_escaping,
                     shots_left, hit_count, duck_idx, round_num, score, game_over});
  endfunction

  initial begin
    //            st    sh    ht   shots act fall esc ld data score hits duck
    vt[0] = '{1'b0, 1'b0, 1'b1, 3, 1, 0, 0, 0, 299,   0, 0, 1};
    vt[1] = '{1'b1, 1'b1, 1'b0, 2, 1, 0, 0, 0, 299,   0, 0, 1};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1, 1, 0, 0, 0, 299,   0, 0, 1};
    vt[3] = '{1'b0, 1'b1, 1'b1, 0, 0, 1, 0, 1,  59, 100, 1, 1};
    vt[4] = '{1'b0, 1'b1, 1'b1, 0, 0, 1, 0, 0,  59, 100, 1, 1};
    vt[5] = '{1'b0, 1'b0, 1'b0, 3, 1, 0, 0, 0, 299, 100, 1, 2};
    vt[6] = '{1'b0, 1'b1, 1'b0, 2, 1, 0, 0, 0, 299, 100, 1, 2};
    vt[7] = '{1'b0, 1'b1, 1'b0, 1, 1, 0, 0, 0, 299, 100, 1, 2};
    vt[8] = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 1, 1,  89, 100, 1, 2};
    vt[9] = '{1'b0, 1'b1, 1'b1, 0, 0, 0, 1, 0,  89, 100, 1, 2};

    reset = 1'b0; start = 1'b0; frame_tick = 1'b0; shot = 1'b0; hit = 1'b0; stale_req = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_outputs", all_outs(), 0);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 0);
    chk("idle_no_start", round_num, 0);

    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("spawn_round", round_num, 1);
    chk("spawn_not_active", duck_active, 0);
    chk("spawn_no_ld", timer_ld, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("fly_active", duck_active, 1);
    chk("fly_ld", timer_ld, 1);
    chk("fly_data", timer_data, 299);
    chk("fly_shots", shots_left, 3);

    // duck 0 times out: one tick every 4 cycles, escape follows the 300th tick
    for (int i = 1; i <= 300; i++) begin
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      if (i >= 299) chk($sformatf("fly_tick%0d_active", i), duck_active, 1);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("timeout_escape", duck_escaping, 1);
    chk("timeout_esc_ld", timer_ld, 1);
    chk("timeout_esc_data", timer_data, 89);
    chk("timeout_shots", shots_left, 3);
    chk("timeout_score", score, 0);

    to_next_fly("duck1");
    for (int i = 0; i < 10; i++) begin
      if (i == 5) to_next_fly("duck2");
      cyc(vt[i].st, vt[i].sh, vt[i].ht, 1'b0);
      chk($sformatf("v%0d_shots", i), shots_left, vt[i].e_shots);
      chk($sformatf("v%0d_active", i), duck_active, vt[i].e_act);
      chk($sformatf("v%0d_fall", i), duck_falling, vt[i].e_fall);
      chk($sformatf("v%0d_esc", i), duck_escaping, vt[i].e_esc);
      chk($sformatf("v%0d_ld", i), timer_ld, vt[i].e_ld);
      chk($sformatf("v%0d_data", i), timer_data, vt[i].e_data);
      chk($sformatf("v%0d_score", i), score, vt[i].e_score);
      chk($sformatf("v%0d_hits", i), hit_count, vt[i].e_hits);
      chk($sformatf("v%0d_duck", i), duck_idx, vt[i].e_duck);
    end

    // duck 3: hit in the same cycle the timer reports done
    to_next_fly("duck3");
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    stale_req = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    stale_req = 1'b0;
    chk("race_still_active", duck_active, 1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("race_fall", duck_falling, 1);
    chk("race_score", score, 200);
    chk("race_hits", hit_count, 2);
    chk("race_shots", shots_left, 2);

    for (int d = 4; d < 10; d++) begin
      to_next_fly("r1");
      chk("r1_duck_idx", duck_idx, d);
      run_duck(d < 8, "r1");
    end
    chk("round_end_ld", timer_ld, 1);
    chk("round_end_data", timer_data, 119);
    chk("round_end_flags", {duck_active, duck_falling, duck_escaping, game_over}, 0);
    chk("round_end_hits", hit_count, 6);
    to_next_fly("r2_start");
    chk("r2_round", round_num, 2);
    chk("r2_hits_clear", hit_count, 0);
    chk("r2_duck_clear", duck_idx, 0);
    chk("r2_score", score, 600);

    play_round(10'b0000011111, "r2");
    wait_game_over("r2");
    repeat (10) cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk("go_hold_flag", game_over, 1);
    chk("go_hold_score", score, 1100);
    chk("go_hold_round", round_num, 2);
    chk("go_hold_hits", hit_count, 5);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart_score", score, 0);
    chk("restart_round", round_num, 1);
    chk("restart_hits", hit_count, 0);
    chk("restart_go", game_over, 0);

    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    play_round(10'b1010101010, "gb");
    wait_game_over("gb");
    chk("gb_score", score, 500);
    chk("gb_round", round_num, 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("gb_restart_score", score, 0);

    // reset in the middle of a fall, then a stale done must not end the first FLY
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("gc_fall", duck_falling, 1);
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("midfall_reset_outputs", all_outs(), 0);
    reset = 1'b1;
    stale_req = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    stale_req = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("stale_spawn", duck_active, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("stale_fly_ld", timer_ld, 1);
    chk("stale_fly_active", duck_active, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("stale_ignored", duck_active, 1);
    chk("stale_ld_drop", timer_ld, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("stale_still_flying", duck_active, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
